// File: rtl/dmem_sized.sv
// Data memory with a valid/ready request port, a fixed number of wait states,
// and byte/half/word accesses with lane steering and sign/zero extension.
module dmem_sized #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] L_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic        w_go_resp;

  logic        r_we, r_uns;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_word;

  logic        r_rsp_valid, r_rsp_err, r_rsp_ld, r_rsp_uns;
  logic [1:0]  r_rsp_lane, r_rsp_size;

  logic        w_a_we, w_a_uns;
  logic [31:0] w_a_addr, w_a_wdata;
  logic [1:0]  w_a_size;
  logic [31:0] w_off;
  logic [1:0]  w_lane;
  logic [AW-1:0] w_idx;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wword;

  // With zero wait states the access commits on the accept edge itself,
  // so the live request inputs are used instead of the latched copy.
  assign w_a_we    = (r_state == IDLE) ? req_we       : r_we;
  assign w_a_uns   = (r_state == IDLE) ? req_unsigned : r_uns;
  assign w_a_addr  = (r_state == IDLE) ? req_addr     : r_addr;
  assign w_a_wdata = (r_state == IDLE) ? req_wdata    : r_wdata;
  assign w_a_size  = (r_state == IDLE) ? req_size     : r_size;

  assign w_off  = w_a_addr - BASE_ADDR;
  assign w_lane = w_off[1:0];
  assign w_idx  = w_off[AW+1:2];

  always_comb begin
    w_err = 1'b0;
    case (w_a_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = w_lane[0];
      2'b10:   w_err = (w_lane != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (w_off >= L_BYTES) w_err = 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_be[gi] = (w_a_size == 2'b00) ? (w_lane == 2'(gi)) :
                      (w_a_size == 2'b01) ? (w_lane[1] == 1'(gi / 2)) : 1'b1;
    assign w_wword[gi*8 +: 8] = (w_a_size == 2'b00) ? w_a_wdata[7:0] :
                                (w_a_size == 2'b01) ? w_a_wdata[(gi % 2)*8 +: 8] :
                                                      w_a_wdata[gi*8 +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_go_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_next = RESP;
            w_go_resp    = 1'b1;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_next = RESP;
          w_go_resp    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == IDLE && req_valid) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
    end
  end

  // Storage has no reset; byte enables map onto RAM write lanes.
  always_ff @(posedge clk) begin
    if (!rst && w_go_resp) begin
      if (w_a_we && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
        end
      end
      r_rd_word <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_rsp_uns   <= 1'b0;
      r_rsp_lane  <= 2'b00;
      r_rsp_size  <= 2'b00;
    end else begin
      r_rsp_valid <= w_go_resp;
      if (w_go_resp) begin
        r_rsp_err  <= w_err;
        r_rsp_ld   <= !w_a_we && !w_err;
        r_rsp_uns  <= w_a_uns;
        r_rsp_lane <= w_lane;
        r_rsp_size <= w_a_size;
      end
    end
  end

  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_rd_ext;

  assign w_rd_byte = r_rd_word[8*r_rsp_lane +: 8];
  assign w_rd_half = r_rsp_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_rd_ext = r_rd_word;
    case (r_rsp_size)
      2'b00:   w_rd_ext = {{24{w_rd_byte[7] & ~r_rsp_uns}}, w_rd_byte};
      2'b01:   w_rd_ext = {{16{w_rd_half[15] & ~r_rsp_uns}}, w_rd_half};
      default: w_rd_ext = r_rd_word;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_ld ? w_rd_ext : 32'h0;

endmodule
